// File: rtl/fetch_pkg.sv
// Shared defaults and the entry type for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_AW = 16;
    localparam int FETCH_DW = 32;
    localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = '0;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [FETCH_DW-1:0] inst;
        logic [FETCH_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions until decode accepts them.
// The head entry is read straight out of register storage, so the outputs have
// no combinational path from any input.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    entry_t           mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] slot_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop needs a valid head; a push needs a free slot or a simultaneous pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Per-slot write enables: only the tail slot is written, never during flush.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
        assign slot_we[gi] = !flush_i && do_push && (tail_q == PW'(gi));
    end

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (do_pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared on reset so the outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    mem_q[i] <= push_data_i;
                end
            end
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a memory
// with a one-cycle registered read, and queues returned words for decode.
// A redirect reloads the PC and squashes both the queue and the read in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            DW       = FETCH_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC),
    parameter int            DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    output logic          imem_write,
    output logic [DW-1:0] imem_wdata,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
    } entry_t;

    logic [AW-1:0] pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          push;
    logic          issue;
    entry_t        push_entry;
    entry_t        head_entry;

    assign pop = inst_valid && inst_ready;

    // Slots already committed after this cycle: buffered plus returning minus leaving.
    // Issuing only while this is below DEPTH guarantees every returning word has room.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue     = !reset && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));

    // The word returning this cycle belongs to inflight_pc_q unless a redirect kills it.
    assign push            = inflight_q && !redirect_valid;
    assign push_entry.inst = imem_rdata;
    assign push_entry.pc   = inflight_pc_q;

    // PC and in-flight tracking; a redirect overrides any issue.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + AW'(1);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count)
    );

    assign imem_addr  = pc_q;
    assign imem_write = 1'b0;
    assign imem_wdata = '0;
    assign inst_valid = (count != '0);
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against a behavioural
// instruction memory and an expected-PC scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int            AW       = 16;
    localparam int            DW       = 32;
    localparam int            DEPTH    = 2;
    localparam logic [AW-1:0] RESET_PC = 16'h0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic          imem_write;
    logic [DW-1:0] imem_wdata;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    int checks = 0;
    int errors = 0;

    // Expected delivery order: the PCs decode must see next, oldest first.
    logic [AW-1:0] sb_q [$];
    logic [AW-1:0] sb_next;

    always #5 clk = ~clk;

    fetch_unit #(
        .AW       (AW),
        .DW       (DW),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_write     (imem_write),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // Memory contents: word at address a is 0xA0 + a.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h0000_00A0 + {16'h0000, a};
    endfunction

    // One-cycle registered read.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Restart the expected stream at a new PC (reset release or redirect).
    task automatic sb_seed(input logic [AW-1:0] target);
        sb_q.delete();
        sb_next = target;
        repeat (16) begin
            sb_q.push_back(sb_next);
            sb_next = sb_next + AW'(1);
        end
    endtask

    // Sampled mid-cycle: invariants plus scoreboard check of any real handshake.
    task automatic observe();
        logic [AW-1:0] exp_pc;
        check_eq("imem_write", 64'(imem_write), 64'd0);
        check_eq("imem_wdata", 64'(imem_wdata), 64'd0);
        checks++;
        assert (int'(dut.u_fifo.count_q) <= DEPTH) else begin
            errors++;
            $error("FAIL count_bound observed=%0d expected<=%0d", dut.u_fifo.count_q, DEPTH);
        end
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty observed_pc=%0h expected=no_delivery", inst_pc);
            end
            if (sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                check_eq("sb_pc", 64'(inst_pc), 64'(exp_pc));
                check_eq("sb_inst", 64'(inst), 64'(mem_word(exp_pc)));
                $display("deliver pc=%04h inst=%08h t=%0t", inst_pc, inst, $time);
                sb_q.push_back(sb_next);
                sb_next = sb_next + AW'(1);
            end
        end
    endtask

    // Finish the current cycle and land just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles, then release; the caller is left in cycle 0.
    task automatic reset_and_release(input int n);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        sb_seed(RESET_PC);
    endtask

    initial begin
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;

        // Outputs while in reset
        check_eq("rst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_pc", 64'(inst_pc), 64'd0);
        check_eq("rst_addr", 64'(imem_addr), 64'(RESET_PC));

        // Reset release with ready high: first instruction in cycle 2, then one per cycle
        inst_ready = 1'b1;
        reset      = 1'b0;
        sb_seed(RESET_PC);
        check_eq("t1_c0_addr", 64'(imem_addr), 64'(RESET_PC));
        check_eq("t1_c0_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t1_c1_valid", 64'(inst_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("t1_valid", 64'(inst_valid), 64'd1);
            check_eq("t1_pc", 64'(inst_pc), 64'(k));
            check_eq("t1_inst", 64'(inst), 64'(32'hA0 + k));
            tick();
        end

        // Back-pressure: ready low from cycle 2 for 5 cycles, PC stalls at 2
        reset_and_release(2);
        inst_ready = 1'b1;
        tick();
        tick();
        inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("t2_hold_valid", 64'(inst_valid), 64'd1);
            check_eq("t2_hold_pc", 64'(inst_pc), 64'd0);
            check_eq("t2_hold_addr", 64'(imem_addr), 64'd2);
            if (k >= 1) begin
                check_eq("t2_hold_count", 64'(dut.u_fifo.count_q), 64'(DEPTH));
            end
            tick();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq("t2_run_valid", 64'(inst_valid), 64'd1);
            check_eq("t2_run_pc", 64'(inst_pc), 64'(k));
            tick();
        end

        // Redirect to 0x0040 while 5 and 6 are buffered and 7 is next to issue
        reset_and_release(1);
        inst_ready = 1'b1;
        repeat (7) tick();
        inst_ready = 1'b0;
        tick();
        check_eq("t3_pre_count", 64'(dut.u_fifo.count_q), 64'd2);
        check_eq("t3_pre_pc", 64'(inst_pc), 64'd5);
        check_eq("t3_pre_addr", 64'(imem_addr), 64'd7);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        sb_seed(16'h0040);
        tick();
        redirect_valid = 1'b0;
        check_eq("t3_r1_addr", 64'(imem_addr), 64'h40);
        check_eq("t3_r1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t3_r2_valid", 64'(inst_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("t3_valid", 64'(inst_valid), 64'd1);
            check_eq("t3_pc", 64'(inst_pc), 64'(16'h0040 + k));
            tick();
        end

        // Redirect mid-stream (read in flight) to 0xFFFE: PC wraps to 0x0000
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        sb_seed(16'hFFFE);
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_r1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t4_r2_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t4_pc0", 64'(inst_pc), 64'hFFFE);
        tick();
        check_eq("t4_pc1", 64'(inst_pc), 64'hFFFF);
        tick();
        check_eq("t4_pc2", 64'(inst_pc), 64'h0000);
        check_eq("t4_inst2", 64'(inst), 64'hA0);
        tick();
        check_eq("t4_pc3", 64'(inst_pc), 64'h0001);
        tick();

        // Reset with a full FIFO, then restart at RESET_PC with cycle-2 latency
        inst_ready = 1'b0;
        repeat (3) tick();
        check_eq("t5_full", 64'(dut.u_fifo.count_q), 64'(DEPTH));
        reset = 1'b1;
        tick();
        check_eq("t5_rst_valid", 64'(inst_valid), 64'd0);
        check_eq("t5_rst_inst", 64'(inst), 64'd0);
        check_eq("t5_rst_pc", 64'(inst_pc), 64'd0);
        check_eq("t5_rst_addr", 64'(imem_addr), 64'(RESET_PC));
        reset      = 1'b0;
        inst_ready = 1'b1;
        sb_seed(RESET_PC);
        check_eq("t5_c0_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t5_c1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t5_c2_valid", 64'(inst_valid), 64'd1);
        check_eq("t5_c2_pc", 64'(inst_pc), 64'(RESET_PC));
        check_eq("t5_c2_inst", 64'(inst), 64'(mem_word(RESET_PC)));
        tick();

        // Random ready with sporadic redirects; the scoreboard checks every delivery
        for (int i = 0; i < 1000; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom_range(0, 65535));
                sb_seed(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (6) tick();
        check_eq("t6_live_valid", 64'(inst_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
